// File: rtl/wb_mon_pkg.sv
// Shared types for the Wishbone classic-cycle bus monitor: FSM states and error codes.
package wb_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HUNG = 2'd2
    } mon_state_e;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_SPURIOUS_ACK = 3'd1,
        ERR_ABORT        = 3'd2,
        ERR_UNSTABLE     = 3'd3,
        ERR_TIMEOUT      = 3'd4
    } err_code_e;

endpackage

// File: rtl/wb_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear; an increment in the clear cycle yields 1.
module wb_mon_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? CNT_W'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_bus_monitor.sv
// Passive Wishbone classic-cycle monitor: flags protocol violations, latches the first
// error with its address, and keeps saturating transfer/error counts and worst ack latency.
module wb_bus_monitor
    import wb_mon_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              o_wb_adr,
    input  logic [DATA_W-1:0]              o_wb_dat,
    input  logic [DATA_W/8-1:0]            o_wb_sel,
    input  logic                           o_wb_we,
    input  logic                           o_wb_cyc,
    input  logic                           o_wb_stb,
    input  logic                           i_wb_ack,
    input  logic                           clr,
    output logic                           err_valid,
    output logic [2:0]                     err_code,
    output logic [ADDR_W-1:0]              err_adr,
    output logic [CNT_W-1:0]               err_count,
    output logic [CNT_W-1:0]               rd_count,
    output logic [CNT_W-1:0]               wr_count,
    output logic [$clog2(TIMEOUT+1)-1:0]   max_lat
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned LAT_W = $clog2(TIMEOUT + 1);

    mon_state_e        state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [ADDR_W-1:0] cap_adr_q, cap_adr_d;
    logic [DATA_W-1:0] cap_dat_q, cap_dat_d;
    logic [SEL_W-1:0]  cap_sel_q, cap_sel_d;
    logic              cap_we_q, cap_we_d;

    logic              err_valid_q, err_valid_d;
    err_code_e         err_code_q, err_code_d;
    logic [ADDR_W-1:0] err_adr_q, err_adr_d;
    logic [LAT_W-1:0]  max_lat_q, max_lat_d;

    logic              req;
    logic              mismatch;
    logic              cmpl, cmpl_we;
    logic [LAT_W-1:0]  cmpl_lat;
    logic              err_ev;
    err_code_e         err_ev_code;
    logic [ADDR_W-1:0] err_ev_adr;

    assign req      = o_wb_cyc & o_wb_stb;
    assign mismatch = (o_wb_adr != cap_adr_q) || (o_wb_we != cap_we_q) ||
                      (o_wb_sel != cap_sel_q) || (cap_we_q && (o_wb_dat != cap_dat_q));

    // One event per cycle at most; the if/else chain in WAIT encodes the reporting priority.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        cap_adr_d   = cap_adr_q;
        cap_dat_d   = cap_dat_q;
        cap_sel_d   = cap_sel_q;
        cap_we_d    = cap_we_q;
        cmpl        = 1'b0;
        cmpl_we     = 1'b0;
        cmpl_lat    = '0;
        err_ev      = 1'b0;
        err_ev_code = ERR_NONE;
        err_ev_adr  = '0;
        case (state_q)
            IDLE: begin
                lat_d = '0;
                if (req && i_wb_ack) begin
                    cmpl    = 1'b1;
                    cmpl_we = o_wb_we;
                end else if (req) begin
                    cap_adr_d = o_wb_adr;
                    cap_we_d  = o_wb_we;
                    cap_sel_d = o_wb_sel;
                    cap_dat_d = o_wb_we ? o_wb_dat : '0;
                    lat_d     = LAT_W'(1);
                    state_d   = WAIT;
                end else if (i_wb_ack) begin
                    err_ev      = 1'b1;
                    err_ev_code = ERR_SPURIOUS_ACK;
                    err_ev_adr  = o_wb_adr;
                end
            end
            WAIT: begin
                if (!req) begin
                    err_ev      = 1'b1;
                    err_ev_code = ERR_ABORT;
                    err_ev_adr  = cap_adr_q;
                    state_d     = IDLE;
                end else if (mismatch) begin
                    err_ev      = 1'b1;
                    err_ev_code = ERR_UNSTABLE;
                    err_ev_adr  = cap_adr_q;
                    state_d     = HUNG;
                end else if (i_wb_ack) begin
                    cmpl     = 1'b1;
                    cmpl_we  = cap_we_q;
                    cmpl_lat = lat_q;
                    state_d  = IDLE;
                end else if (lat_q == LAT_W'(TIMEOUT)) begin
                    err_ev      = 1'b1;
                    err_ev_code = ERR_TIMEOUT;
                    err_ev_adr  = cap_adr_q;
                    state_d     = HUNG;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            HUNG: begin
                if (!req || i_wb_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear is applied first so a same-cycle event lands on the freshly cleared state.
    always_comb begin
        err_valid_d = clr ? 1'b0 : err_valid_q;
        err_code_d  = clr ? ERR_NONE : err_code_q;
        err_adr_d   = clr ? '0 : err_adr_q;
        max_lat_d   = clr ? '0 : max_lat_q;
        if (err_ev && !err_valid_d) begin
            err_valid_d = 1'b1;
            err_code_d  = err_ev_code;
            err_adr_d   = err_ev_adr;
        end
        if (cmpl && (cmpl_lat > max_lat_d)) begin
            max_lat_d = cmpl_lat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            cap_adr_q   <= '0;
            cap_dat_q   <= '0;
            cap_sel_q   <= '0;
            cap_we_q    <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_adr_q   <= '0;
            max_lat_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            cap_adr_q   <= cap_adr_d;
            cap_dat_q   <= cap_dat_d;
            cap_sel_q   <= cap_sel_d;
            cap_we_q    <= cap_we_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_adr_q   <= err_adr_d;
            max_lat_q   <= max_lat_d;
        end
    end

    wb_mon_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (err_ev),
        .cnt_o (err_count)
    );

    wb_mon_sat_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (cmpl && !cmpl_we),
        .cnt_o (rd_count)
    );

    wb_mon_sat_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (cmpl && cmpl_we),
        .cnt_o (wr_count)
    );

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_adr   = err_adr_q;
    assign max_lat   = max_lat_q;

endmodule

// File: tb/tb_wb_bus_monitor.sv
// Directed bench for wb_bus_monitor: expected status is queued with each stimulus step and
// popped against the registered outputs one time unit after the clock edge.
module tb_wb_bus_monitor;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LAT_W   = $clog2(TIMEOUT + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic [3:0]        sel;
    logic              we, cyc, stb, ack, clr;

    logic              err_valid;
    logic [2:0]        err_code;
    logic [ADDR_W-1:0] err_adr;
    logic [CNT_W-1:0]  err_count, rd_count, wr_count;
    logic [LAT_W-1:0]  max_lat;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        string       tag;
        int unsigned id;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    wb_bus_monitor #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .o_wb_adr  (adr),
        .o_wb_dat  (dat),
        .o_wb_sel  (sel),
        .o_wb_we   (we),
        .o_wb_cyc  (cyc),
        .o_wb_stb  (stb),
        .i_wb_ack  (ack),
        .clr       (clr),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_adr   (err_adr),
        .err_count (err_count),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .max_lat   (max_lat)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int unsigned id);
        case (id)
            0:       return 32'(err_valid);
            1:       return 32'(err_code);
            2:       return err_adr;
            3:       return 32'(err_count);
            4:       return 32'(rd_count);
            5:       return 32'(wr_count);
            default: return 32'(max_lat);
        endcase
    endfunction

    task automatic push(input string tag, input int unsigned id, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.id  = id;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_all(input string tag, input logic [31:0] ev, input logic [31:0] code,
                            input logic [31:0] eadr, input logic [31:0] ecnt,
                            input logic [31:0] rd, input logic [31:0] wr,
                            input logic [31:0] ml);
        push({tag, ".err_valid"}, 0, ev);
        push({tag, ".err_code"},  1, code);
        push({tag, ".err_adr"},   2, eadr);
        push({tag, ".err_count"}, 3, ecnt);
        push({tag, ".rd_count"},  4, rd);
        push({tag, ".wr_count"},  5, wr);
        push({tag, ".max_lat"},   6, ml);
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.id);
            n_tests++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cyc = 1'b0;
        stb = 1'b0;
        ack = 1'b0;
        we  = 1'b0;
    endtask

    task automatic request(input logic [31:0] a, input logic w, input logic [31:0] d);
        adr = a;
        we  = w;
        dat = d;
        sel = 4'hF;
        cyc = 1'b1;
        stb = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        adr = '0;
        dat = '0;
        sel = '0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_all("reset", 0, 0, 0, 0, 0, 0, 0);
        check();

        // Single read, ack on the fourth req cycle -> latency 3
        request(32'h40, 1'b0, 32'h0);
        repeat (3) step();
        ack = 1'b1;
        push_all("read_lat3", 0, 0, 0, 0, 1, 0, 3);
        step();
        check();
        bus_idle();

        clr = 1'b1;
        push_all("clr_idle", 0, 0, 0, 0, 0, 0, 0);
        step();
        check();
        clr = 1'b0;

        // Four zero-wait writes
        request(32'h200, 1'b1, 32'h1234);
        ack = 1'b1;
        push_all("zero_wait_wr", 0, 0, 0, 0, 0, 4, 0);
        repeat (4) step();
        check();
        bus_idle();

        // Read with no ack: timeout on the 17th edge of req
        request(32'h300, 1'b0, 32'h0);
        repeat (16) step();
        push("pre_timeout.err_valid", 0, 0);
        check();
        push_all("timeout", 1, 4, 32'h300, 1, 0, 4, 0);
        step();
        check();
        ack = 1'b1;
        push_all("hung_ack", 1, 4, 32'h300, 1, 0, 4, 0);
        step();
        check();
        bus_idle();
        step();

        // Ack exactly at lat == TIMEOUT is a legal completion
        request(32'h310, 1'b0, 32'h0);
        repeat (16) step();
        ack = 1'b1;
        push_all("ack_at_timeout", 1, 4, 32'h300, 1, 1, 4, 16);
        step();
        check();
        bus_idle();

        clr = 1'b1;
        step();
        clr = 1'b0;

        // Strobe dropped mid-wait, then an ack with no request
        request(32'h400, 1'b1, 32'hAAAA);
        repeat (2) step();
        stb = 1'b0;
        push_all("abort", 1, 2, 32'h400, 1, 0, 0, 0);
        step();
        check();
        cyc = 1'b0;
        adr = 32'h480;
        ack = 1'b1;
        push_all("spurious_after_abort", 1, 2, 32'h400, 2, 0, 0, 0);
        step();
        check();
        bus_idle();

        clr = 1'b1;
        step();
        clr = 1'b0;

        // Address changes during a write wait
        request(32'h100, 1'b1, 32'h55);
        step();
        adr = 32'h104;
        push_all("unstable", 1, 3, 32'h100, 1, 0, 0, 0);
        step();
        check();
        bus_idle();
        step();

        // Clear coinciding with a timeout: the timeout becomes the first error
        request(32'h500, 1'b0, 32'h0);
        repeat (16) step();
        clr = 1'b1;
        push_all("clr_with_timeout", 1, 4, 32'h500, 1, 0, 0, 0);
        step();
        check();
        clr = 1'b0;
        bus_idle();
        step();

        // Clear coinciding with a zero-wait write
        clr = 1'b1;
        request(32'h600, 1'b1, 32'h77);
        ack = 1'b1;
        push_all("clr_with_write", 0, 0, 0, 0, 0, 1, 0);
        step();
        check();
        clr = 1'b0;
        bus_idle();

        // Saturation of the read counter
        request(32'h610, 1'b0, 32'h0);
        ack = 1'b1;
        push_all("rd_saturate", 0, 0, 0, 0, 15, 1, 0);
        repeat (20) step();
        check();
        bus_idle();

        // Saturation of the error counter via repeated spurious acks
        adr = 32'h700;
        ack = 1'b1;
        push_all("err_saturate", 1, 1, 32'h700, 15, 15, 1, 0);
        repeat (20) step();
        check();
        bus_idle();

        // Asynchronous reset in the middle of a transfer
        request(32'h800, 1'b0, 32'h0);
        repeat (2) step();
        rst = 1'b1;
        #1;
        push_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
        check();
        bus_idle();
        rst = 1'b0;
        push_all("after_reset", 0, 0, 0, 0, 0, 0, 0);
        step();
        check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_bus_monitor.md
# wb_bus_monitor

Synthesizable, parametrised Wishbone classic-cycle protocol monitor. It sits passively on the ARM core's master-side Wishbone port and taps the same signals the core drives and receives. It detects protocol violations (spurious ack, aborted strobe, unstable request, ack timeout), captures the first error with its address, and keeps read/write transfer counts and the worst-case ack latency for debug readout.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; SEL_W = DATA_W/8
- TIMEOUT, 16, maximum allowed wait cycles before ack (≥1)
- CNT_W, 16, width of transfer and error counters (saturating)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- o_wb_adr  in  ADDR_W  master address
- o_wb_dat  in  DATA_W  master write data
- o_wb_sel  in  SEL_W  byte selects
- o_wb_we  in  1  write enable
- o_wb_cyc  in  1  cycle valid
- o_wb_stb  in  1  strobe
- i_wb_ack  in  1  slave acknowledge
- clr  in  1  synchronous clear of error state and counters
- err_valid  out  1  sticky: at least one error since reset/clr
- err_code  out  3  code of first error: 0 none, 1 SPURIOUS_ACK, 2 ABORT, 3 UNSTABLE, 4 TIMEOUT
- err_adr  out  ADDR_W  captured request address of first error
- err_count  out  CNT_W  total errors, saturating
- rd_count  out  CNT_W  completed reads, saturating
- wr_count  out  CNT_W  completed writes, saturating
- max_lat  out  LAT_W  worst ack latency seen; LAT_W = $clog2(TIMEOUT+1)

## Operation
- req = o_wb_cyc & o_wb_stb. FSM states: IDLE, WAIT, HUNG.
- IDLE: req & ack -> zero-latency completion, count, stay IDLE. req & !ack -> capture adr/we/sel/dat (dat only if we), lat<=1, go WAIT. !req & ack -> SPURIOUS_ACK, error address = o_wb_adr.
- WAIT, evaluated in this priority: !req -> ABORT, go IDLE. Else adr/we/sel differ from capture (or dat when captured we=1) -> UNSTABLE, go HUNG. Else ack -> completion with latency = lat, go IDLE. Else lat==TIMEOUT -> TIMEOUT, go HUNG. Else lat++.
- HUNG: return to IDLE when !req or ack. Ack here is neither counted nor flagged.
- Completion: increment rd_count or wr_count (captured we, or live o_wb_we in the IDLE zero-latency case). max_lat <= max(max_lat, latency).
- Error: err_count++ (saturate). If err_valid=0, latch err_code and err_adr and set err_valid. Error address is the captured address in WAIT, live address in IDLE.
- Only one error is reported per cycle, by the priority above.
- clr: zeroes err_valid, err_code, err_adr, err_count, rd_count, wr_count, max_lat. It does not affect the FSM. A same-cycle error or completion is applied after the clear: it becomes the first error, or a count of 1.
- All counters saturate at all-ones. No wrap.

## Timing
- Reset: FSM=IDLE, lat=0, every output 0.
- All outputs registered. An event seen at edge N is visible after edge N (one-cycle latency).
- Latency = number of cycles req was high before the ack cycle. A TIMEOUT fires on the edge where TIMEOUT consecutive wait cycles have passed with no ack. An ack arriving while lat==TIMEOUT is a legal completion.
- Back-to-back transfers: after a completion in WAIT, the next req is evaluated from IDLE on the following cycle. A zero-latency completion in IDLE allows one transfer per cycle.
- Asynchronous reset mid-transfer aborts monitoring immediately and sets no error.

## Structure
- Package wb_mon_pkg: state enum (IDLE, WAIT, HUNG) and err_code_e constants (ERR_NONE..ERR_TIMEOUT).
- One sub-module: wb_mon_sat_cnt (parametrised CNT_W saturating counter with inc and clr), instantiated for err_count, rd_count and wr_count.

## Test plan
- Reset, then single read: req at cycle 0, ack at cycle 3 -> rd_count=1, max_lat=3, err_valid=0.
- Zero-wait writes: req & ack high for 4 consecutive cycles -> wr_count=4, max_lat=0.
- Timeout: TIMEOUT=16, req held with no ack -> at 16 waits err_code=4, err_adr=request address, err_count=1. A later ack in HUNG is not counted. Ack at exactly lat=16 -> completion, no error.
- Abort then spurious ack: stb dropped in WAIT -> err_code=2. A subsequent ack with req=0 -> err_count=2, err_code stays 2.
- Unstable: o_wb_adr changes 0x100 -> 0x104 during WAIT of a write -> err_code=3, err_adr=0x100.
- clr asserted in the same cycle as a TIMEOUT -> err_valid=1, err_code=4, err_count=1. Counters at all-ones stay saturated with no wrap.
